// File: rtl/acl_spi_responder_pkg.sv
`timescale 1ns/1ps
// Shared constants, FSM state type and address helpers for the ADXL362-style responder.
package acl_pkg;

   // Read-only identification registers
   localparam logic [7:0] DEVID_AD  = 8'hAD;
   localparam logic [7:0] DEVID_MST = 8'h1D;
   localparam logic [7:0] PARTID    = 8'hF2;

   // SPI command bytes
   localparam logic [7:0] CMD_WRITE = 8'h0A;
   localparam logic [7:0] CMD_READ  = 8'h0B;

   // Register map
   localparam logic [5:0] ADDR_DEVID_AD   = 6'h00;
   localparam logic [5:0] ADDR_DEVID_MST  = 6'h01;
   localparam logic [5:0] ADDR_PARTID     = 6'h02;
   localparam logic [5:0] ADDR_XDATA      = 6'h08;
   localparam logic [5:0] ADDR_YDATA      = 6'h09;
   localparam logic [5:0] ADDR_ZDATA      = 6'h0A;
   localparam logic [5:0] ADDR_SOFT_RESET = 6'h1F;
   localparam logic [5:0] WR_LO           = 6'h1F;
   localparam logic [5:0] WR_HI           = 6'h2E;
   // First address that is actually stored (0x1F is write-only, reads 0x00)
   localparam logic [5:0] RF_LO           = 6'h20;
   localparam int         RF_DEPTH        = 15;

   localparam logic [7:0] SOFT_RESET_KEY  = 8'h52;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_READ   = 3'd4,
      ST_IGNORE = 3'd5
   } state_e;

   // True for addresses that accept a write (and produce a strobe)
   function automatic logic is_writable(input logic [5:0] a);
      return (a >= WR_LO) && (a <= WR_HI);
   endfunction

   // True for addresses backed by a storage register
   function automatic logic is_stored(input logic [5:0] a);
      return (a >= RF_LO) && (a <= WR_HI);
   endfunction

   // Storage index for an address in RF_LO..WR_HI
   function automatic logic [3:0] rf_idx(input logic [5:0] a);
      return 4'(a - RF_LO);
   endfunction

endpackage

// File: rtl/acl_spi_responder_if.sv
`timescale 1ns/1ps
// Accelerometer SPI bus: the maze master drives clock/data/select, the responder drives MISO.
interface acl_spi_responder_if;
   logic ACL_SCLK;
   logic ACL_MOSI;
   logic ACL_CSN;
   logic ACL_MISO;

   modport master (output ACL_SCLK, output ACL_MOSI, output ACL_CSN, input ACL_MISO);
   modport slave  (input ACL_SCLK, input ACL_MOSI, input ACL_CSN, output ACL_MISO);
endinterface

// File: rtl/acl_spi_responder_spi_sync_edge.sv
`timescale 1ns/1ps
// Two-flop synchronizer with a registered rise/fall detector; pulses appear
// three clk cycles after the asynchronous input changes. All flops reset low so
// a select line that is already low out of reset does not look like a fresh fall.
module spi_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic rise_q;
   logic fall_q;

   // Synchronize the input and register single-cycle edge pulses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         rise_q  <= sync2_q & ~prev_q;
         fall_q  <= ~sync2_q & prev_q;
      end
   end

   assign level_o = sync2_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
endmodule

// File: rtl/acl_spi_responder.sv
`timescale 1ns/1ps
// SPI mode-0 responder emulating the ADXL362 register interface, oversampled on clk108MHz.
module acl_spi_responder
   import acl_pkg::*;
(
   input  logic                clk108MHz,
   input  logic                resetPressed,
   acl_spi_responder_if.slave  spi,
   input  logic [7:0]          xData,
   input  logic [7:0]          yData,
   input  logic [7:0]          zData,
   output logic                regWrStrobe,
   output logic [5:0]          regWrAddr,
   output logic [7:0]          regWrData,
   output logic                xferDone
);
   logic sclk_rise_s, sclk_fall_s, sclk_level_unused_s;
   logic csn_rise_s, csn_fall_s, csn_level_s;
   logic mosi_s1_q, mosi_s2_q;

   state_e      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_in_q, shift_in_d;
   logic [7:0]  shift_out_q, shift_out_d;
   logic [5:0]  addr_q, addr_d;
   logic        dir_wr_q, dir_wr_d;
   logic        soft_pend_q, soft_pend_d;
   logic [7:0]  snap_x_q, snap_x_d, snap_y_q, snap_y_d, snap_z_q, snap_z_d;
   logic [7:0]  regs_q [0:RF_DEPTH-1];
   logic [7:0]  regs_d [0:RF_DEPTH-1];
   logic        miso_q, miso_d;
   logic        wr_strobe_q, wr_strobe_d;
   logic [5:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        xfer_done_q, xfer_done_d;
   logic [7:0]  rx_byte_s;
   logic        byte_done_s;
   logic [7:0]  rd_data_s;

   spi_sync_edge u_sclk (
      .clk_i   (clk108MHz),
      .rst_i   (resetPressed),
      .d_i     (spi.ACL_SCLK),
      .level_o (sclk_level_unused_s),
      .rise_o  (sclk_rise_s),
      .fall_o  (sclk_fall_s)
   );

   spi_sync_edge u_csn (
      .clk_i   (clk108MHz),
      .rst_i   (resetPressed),
      .d_i     (spi.ACL_CSN),
      .level_o (csn_level_s),
      .rise_o  (csn_rise_s),
      .fall_o  (csn_fall_s)
   );

   // MOSI only needs the two-flop synchronizer; it is stable around every SCLK rise
   always_ff @(posedge clk108MHz or posedge resetPressed) begin
      if (resetPressed) begin
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         mosi_s1_q <= spi.ACL_MOSI;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   assign rx_byte_s   = {shift_in_q[6:0], mosi_s2_q};
   assign byte_done_s = sclk_rise_s && (bit_cnt_q == 3'd7);

   // Register read mux; unmapped addresses and the write-only soft reset read 0x00
   always_comb begin
      rd_data_s = 8'h00;
      case (addr_q)
         ADDR_DEVID_AD:  rd_data_s = DEVID_AD;
         ADDR_DEVID_MST: rd_data_s = DEVID_MST;
         ADDR_PARTID:    rd_data_s = PARTID;
         ADDR_XDATA:     rd_data_s = snap_x_q;
         ADDR_YDATA:     rd_data_s = snap_y_q;
         ADDR_ZDATA:     rd_data_s = snap_z_q;
         default: begin
            if (is_stored(addr_q)) begin
               rd_data_s = regs_q[rf_idx(addr_q)];
            end else begin
               rd_data_s = 8'h00;
            end
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk108MHz or posedge resetPressed) begin
      if (resetPressed) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: CSN rise always wins, byte boundaries advance the protocol
   always_comb begin
      state_d = state_q;
      if (state_q == ST_IDLE) begin
         if (csn_fall_s) begin
            state_d = ST_CMD;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (csn_rise_s) begin
         state_d = ST_IDLE;
      end else if (byte_done_s) begin
         case (state_q)
            ST_CMD: begin
               if ((rx_byte_s == CMD_WRITE) || (rx_byte_s == CMD_READ)) begin
                  state_d = ST_ADDR;
               end else begin
                  state_d = ST_IGNORE;
               end
            end
            ST_ADDR: begin
               if (dir_wr_q) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end
            default: state_d = state_q;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Datapath next state: shifting, address tracking, register writes and pulses
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_in_d  = shift_in_q;
      shift_out_d = shift_out_q;
      addr_d      = addr_q;
      dir_wr_d    = dir_wr_q;
      soft_pend_d = soft_pend_q;
      snap_x_d    = snap_x_q;
      snap_y_d    = snap_y_q;
      snap_z_d    = snap_z_q;
      regs_d      = regs_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      xfer_done_d = 1'b0;
      if (state_q == ST_IDLE) begin
         if (csn_fall_s) begin
            // Snapshot tilt samples so a multi-byte read is coherent
            bit_cnt_d   = 3'd0;
            shift_out_d = 8'h00;
            soft_pend_d = 1'b0;
            snap_x_d    = xData;
            snap_y_d    = yData;
            snap_z_d    = zData;
         end else begin
            bit_cnt_d = bit_cnt_q;
         end
      end else if (csn_rise_s) begin
         // End of transaction: drop any partial byte, apply a pending soft reset
         xfer_done_d = 1'b1;
         bit_cnt_d   = 3'd0;
         soft_pend_d = 1'b0;
         if (soft_pend_q) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
               regs_d[i] = 8'h00;
            end
         end else begin
            soft_pend_d = 1'b0;
         end
      end else if (sclk_rise_s) begin
         shift_in_d = rx_byte_s;
         bit_cnt_d  = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            case (state_q)
               ST_CMD:  dir_wr_d = (rx_byte_s == CMD_WRITE);
               ST_ADDR: addr_d   = rx_byte_s[5:0];
               ST_WRITE: begin
                  addr_d = addr_q + 6'd1;
                  if (is_writable(addr_q)) begin
                     wr_strobe_d = 1'b1;
                     wr_addr_d   = addr_q;
                     wr_data_d   = rx_byte_s;
                     if (addr_q == ADDR_SOFT_RESET) begin
                        soft_pend_d = soft_pend_q | (rx_byte_s == SOFT_RESET_KEY);
                     end else begin
                        regs_d[rf_idx(addr_q)] = rx_byte_s;
                     end
                  end else begin
                     wr_strobe_d = 1'b0;
                  end
               end
               default: dir_wr_d = dir_wr_q;
            endcase
         end else begin
            dir_wr_d = dir_wr_q;
         end
      end else if (sclk_fall_s && (state_q == ST_READ)) begin
         // First fall of each byte loads the next register, later falls shift
         if (bit_cnt_q == 3'd0) begin
            shift_out_d = rd_data_s;
            addr_d      = addr_q + 6'd1;
         end else begin
            shift_out_d = {shift_out_q[6:0], 1'b0};
         end
      end else begin
         bit_cnt_d = bit_cnt_q;
      end
   end

   // Output decode: MISO only carries data while reading with CSN low
   always_comb begin
      if ((state_d == ST_READ) && !csn_level_s) begin
         miso_d = shift_out_d[7];
      end else begin
         miso_d = 1'b0;
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk108MHz or posedge resetPressed) begin
      if (resetPressed) begin
         bit_cnt_q   <= 3'd0;
         shift_in_q  <= 8'h00;
         shift_out_q <= 8'h00;
         addr_q      <= 6'h00;
         dir_wr_q    <= 1'b0;
         soft_pend_q <= 1'b0;
         snap_x_q    <= 8'h00;
         snap_y_q    <= 8'h00;
         snap_z_q    <= 8'h00;
         for (int i = 0; i < RF_DEPTH; i++) begin
            regs_q[i] <= 8'h00;
         end
         miso_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= 6'h00;
         wr_data_q   <= 8'h00;
         xfer_done_q <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         shift_in_q  <= shift_in_d;
         shift_out_q <= shift_out_d;
         addr_q      <= addr_d;
         dir_wr_q    <= dir_wr_d;
         soft_pend_q <= soft_pend_d;
         snap_x_q    <= snap_x_d;
         snap_y_q    <= snap_y_d;
         snap_z_q    <= snap_z_d;
         for (int i = 0; i < RF_DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
         miso_q      <= miso_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         xfer_done_q <= xfer_done_d;
      end
   end

   assign spi.ACL_MISO = miso_q;
   assign regWrStrobe  = wr_strobe_q;
   assign regWrAddr    = wr_addr_q;
   assign regWrData    = wr_data_q;
   assign xferDone     = xfer_done_q;
endmodule

// File: tb/tb_acl_spi_responder.sv
`timescale 1ns/1ps
// Directed bench: emulates the maze SPI master at 5 MHz and checks responder behaviour.
module tb_acl_spi_responder;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] x_data, y_data, z_data;
   logic       wr_strobe, xfer_done;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;

   int checks   = 0;
   int failures = 0;
   int strobe_cnt = 0;
   int done_cnt   = 0;
   logic [5:0] log_addr [$];
   logic [7:0] log_data [$];

   acl_spi_responder_if spi_bus ();

   acl_spi_responder dut (
      .clk108MHz    (clk),
      .resetPressed (rst),
      .spi          (spi_bus),
      .xData        (x_data),
      .yData        (y_data),
      .zData        (z_data),
      .regWrStrobe  (wr_strobe),
      .regWrAddr    (wr_addr),
      .regWrData    (wr_data),
      .xferDone     (xfer_done)
   );

   always #4.63 clk = ~clk;

   // Log write strobes and transfer-done pulses away from the active edge
   always @(negedge clk) begin
      if (wr_strobe) begin
         strobe_cnt++;
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
      end
      if (xfer_done) done_cnt++;
   end

   // Absolute time bound for the whole run
   initial begin
      #2ms;
      $display("FAIL timeout: run still active at 2 ms, required finish");
      $fatal(1, "timeout");
   end

   // One mode-0 byte: set data while SCLK low, sample MISO just before the rise
   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         spi_bus.ACL_MOSI = tx[i];
         #100;
         rx[i] = spi_bus.ACL_MISO;
         spi_bus.ACL_SCLK = 1'b1;
         #100;
         spi_bus.ACL_SCLK = 1'b0;
      end
   endtask

   task automatic spi_begin();
      spi_bus.ACL_CSN = 1'b0;
      #200;
   endtask

   task automatic spi_end();
      #200;
      spi_bus.ACL_CSN = 1'b1;
      #400;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #50;
      checks++; if (spi_bus.ACL_MISO !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", spi_bus.ACL_MISO); end
      checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", wr_strobe); end
      checks++; if (wr_addr !== 6'h00) begin failures++; $display("FAIL reset_wraddr got=%h exp=00", wr_addr); end
      checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wrdata got=%h exp=00", wr_data); end
      checks++; if (xfer_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", xfer_done); end
      rst = 1'b0;
      #300;
      checks++; if (done_cnt !== 0) begin failures++; $display("FAIL no_fall_no_done got=%0d exp=0", done_cnt); end
   endtask

   task automatic test_read_id();
      logic [7:0] rx, b0, b1, b2;
      int d0;
      d0 = done_cnt;
      spi_begin();
      spi_byte(8'h0B, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, b0);
      spi_byte(8'h00, b1);
      spi_byte(8'h00, b2);
      spi_end();
      checks++; if (b0 !== 8'hAD) begin failures++; $display("FAIL id_devid_ad got=%h exp=AD", b0); end
      checks++; if (b1 !== 8'h1D) begin failures++; $display("FAIL id_devid_mst got=%h exp=1D", b1); end
      checks++; if (b2 !== 8'hF2) begin failures++; $display("FAIL id_partid got=%h exp=F2", b2); end
      checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL id_xferdone got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_snapshot();
      logic [7:0] rx, b0, b1, b2;
      x_data = 8'h12; y_data = 8'hFE; z_data = 8'h40;
      spi_begin();
      spi_byte(8'h0B, rx);
      spi_byte(8'h08, rx);
      spi_byte(8'h00, b0);
      x_data = 8'h77; y_data = 8'h01; z_data = 8'h99;
      spi_byte(8'h00, b1);
      spi_byte(8'h00, b2);
      spi_end();
      checks++; if (b0 !== 8'h12) begin failures++; $display("FAIL snap_x got=%h exp=12", b0); end
      checks++; if (b1 !== 8'hFE) begin failures++; $display("FAIL snap_y got=%h exp=FE", b1); end
      checks++; if (b2 !== 8'h40) begin failures++; $display("FAIL snap_z got=%h exp=40", b2); end
   endtask

   task automatic test_write_burst();
      logic [7:0] rx;
      int s0;
      s0 = strobe_cnt;
      spi_begin();
      spi_byte(8'h0A, rx);
      spi_byte(8'h2C, rx);
      spi_byte(8'h13, rx);
      spi_byte(8'h02, rx);
      spi_end();
      checks++; if (strobe_cnt - s0 !== 2) begin failures++; $display("FAIL wr_strobe_count got=%0d exp=2", strobe_cnt - s0); end
      if (strobe_cnt - s0 >= 2) begin
         checks++; if (log_addr[s0] !== 6'h2C) begin failures++; $display("FAIL wr0_addr got=%h exp=2C", log_addr[s0]); end
         checks++; if (log_data[s0] !== 8'h13) begin failures++; $display("FAIL wr0_data got=%h exp=13", log_data[s0]); end
         checks++; if (log_addr[s0+1] !== 6'h2D) begin failures++; $display("FAIL wr1_addr got=%h exp=2D", log_addr[s0+1]); end
         checks++; if (log_data[s0+1] !== 8'h02) begin failures++; $display("FAIL wr1_data got=%h exp=02", log_data[s0+1]); end
      end
      spi_begin();
      spi_byte(8'h0B, rx);
      spi_byte(8'h2C, rx);
      spi_byte(8'h00, rx);
      spi_end();
      checks++; if (rx !== 8'h13) begin failures++; $display("FAIL wr_readback got=%h exp=13", rx); end
   endtask

   task automatic test_invalid();
      logic [7:0] rx, b0, b1;
      int s0;
      s0 = strobe_cnt;
      spi_begin();
      spi_byte(8'h0A, rx);
      spi_byte(8'h08, rx);
      spi_byte(8'h55, rx);
      spi_end();
      checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL ro_write_strobe got=%0d exp=%0d", strobe_cnt, s0); end
      spi_begin();
      spi_byte(8'h0D, rx);
      spi_byte(8'h00, b0);
      spi_byte(8'hFF, b1);
      spi_end();
      checks++; if ((b0 | b1) !== 8'h00) begin failures++; $display("FAIL ignore_miso got=%h exp=00", b0 | b1); end
      checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL ignore_strobe got=%0d exp=%0d", strobe_cnt, s0); end
      spi_begin();
      spi_byte(8'h0B, rx);
      spi_byte(8'h01, rx);
      spi_byte(8'h00, rx);
      spi_end();
      checks++; if (rx !== 8'h1D) begin failures++; $display("FAIL after_ignore_read got=%h exp=1D", rx); end
   endtask

   task automatic test_wrap_partial();
      logic [7:0] rx, b0, b1;
      int s0;
      spi_begin();
      spi_byte(8'h0B, rx);
      spi_byte(8'hFF, rx);
      spi_byte(8'h00, b0);
      spi_byte(8'h00, b1);
      spi_end();
      checks++; if (b0 !== 8'h00) begin failures++; $display("FAIL wrap_unmapped got=%h exp=00", b0); end
      checks++; if (b1 !== 8'hAD) begin failures++; $display("FAIL wrap_to_zero got=%h exp=AD", b1); end
      s0 = strobe_cnt;
      spi_begin();
      spi_byte(8'h0A, rx);
      spi_byte(8'h2C, rx);
      for (int i = 0; i < 4; i++) begin
         spi_bus.ACL_MOSI = 1'b1;
         #100;
         spi_bus.ACL_SCLK = 1'b1;
         #100;
         spi_bus.ACL_SCLK = 1'b0;
      end
      spi_end();
      checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL partial_strobe got=%0d exp=%0d", strobe_cnt, s0); end
      spi_begin();
      spi_byte(8'h0B, rx);
      spi_byte(8'h2C, rx);
      spi_byte(8'h00, rx);
      spi_end();
      checks++; if (rx !== 8'h13) begin failures++; $display("FAIL partial_keep got=%h exp=13", rx); end
   endtask

   task automatic test_soft_reset();
      logic [7:0] rx, b0, b1;
      int s0;
      s0 = strobe_cnt;
      spi_begin();
      spi_byte(8'h0A, rx);
      spi_byte(8'h1F, rx);
      spi_byte(8'h52, rx);
      spi_end();
      checks++; if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL sr_strobe got=%0d exp=1", strobe_cnt - s0); end
      if (strobe_cnt - s0 >= 1) begin
         checks++; if ({log_addr[s0], log_data[s0]} !== {6'h1F, 8'h52}) begin failures++; $display("FAIL sr_strobe_val got=%h/%h exp=1F/52", log_addr[s0], log_data[s0]); end
      end
      spi_begin();
      spi_byte(8'h0B, rx);
      spi_byte(8'h2C, rx);
      spi_byte(8'h00, b0);
      spi_byte(8'h00, b1);
      spi_end();
      checks++; if (b0 !== 8'h00) begin failures++; $display("FAIL sr_clear_2c got=%h exp=00", b0); end
      checks++; if (b1 !== 8'h00) begin failures++; $display("FAIL sr_clear_2d got=%h exp=00", b1); end
      spi_begin();
      spi_byte(8'h0B, rx);
      spi_byte(8'h1F, rx);
      spi_byte(8'h00, rx);
      spi_end();
      checks++; if (rx !== 8'h00) begin failures++; $display("FAIL sr_read_1f got=%h exp=00", rx); end
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] rx;
      int d0;
      spi_begin();
      spi_byte(8'h0B, rx);
      spi_byte(8'h00, rx);
      #60;
      checks++; if (spi_bus.ACL_MISO !== 1'b1) begin failures++; $display("FAIL mid_read_msb got=%b exp=1", spi_bus.ACL_MISO); end
      rst = 1'b1;
      #1;
      checks++; if (spi_bus.ACL_MISO !== 1'b0) begin failures++; $display("FAIL rst_miso got=%b exp=0", spi_bus.ACL_MISO); end
      #50;
      rst = 1'b0;
      d0 = done_cnt;
      spi_byte(8'h00, rx);
      checks++; if (rx !== 8'h00) begin failures++; $display("FAIL rst_no_resume got=%h exp=00", rx); end
      spi_end();
      checks++; if (done_cnt !== d0) begin failures++; $display("FAIL rst_no_done got=%0d exp=%0d", done_cnt, d0); end
      spi_begin();
      spi_byte(8'h0B, rx);
      spi_byte(8'h02, rx);
      spi_byte(8'h00, rx);
      spi_end();
      checks++; if (rx !== 8'hF2) begin failures++; $display("FAIL rst_fresh_read got=%h exp=F2", rx); end
   endtask

   // Sequence of directed scenarios
   initial begin
      spi_bus.ACL_SCLK = 1'b0;
      spi_bus.ACL_MOSI = 1'b0;
      spi_bus.ACL_CSN  = 1'b1;
      x_data = 8'h00; y_data = 8'h00; z_data = 8'h00;
      rst = 1'b1;
      test_reset();
      test_read_id();
      test_snapshot();
      test_write_burst();
      test_invalid();
      test_wrap_partial();
      test_soft_reset();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/acl_spi_responder.md
# acl_spi_responder

SPI mode-0 responder that emulates the ADXL362 accelerometer's register interface: the far end of the ACL_SCLK/ACL_MOSI/ACL_CSN/ACL_MISO bus driven by the maze's accelerometer master. It oversamples the bus on the 108 MHz video clock, decodes read/write commands with address auto-increment, and serves tilt samples from ports. It is the closed-loop stimulus for the maze's tilt path, in simulation and in the board loopback build (Pmod-to-Pmod wiring).

## Interface
- DEVID_AD, 8'hAD, value returned at address 0x00
- DEVID_MST, 8'h1D, value returned at address 0x01
- PARTID, 8'hF2, value returned at address 0x02
- clk108MHz  in  1  sole clock
- resetPressed  in  1  asynchronous, active-high reset
- ACL_SCLK  in  1  SPI clock from master, asynchronous to clk108MHz
- ACL_MOSI  in  1  serial data from master
- ACL_CSN  in  1  chip select, active low
- ACL_MISO  out  1  serial data to master
- xData, yData, zData  in  8 each  signed tilt samples served at 0x08/0x09/0x0A
- regWrStrobe  out  1  one-cycle pulse per committed write
- regWrAddr  out  6  address of committed write
- regWrData  out  8  data of committed write
- xferDone  out  1  one-cycle pulse when CSN deasserts after a transaction

## Operation
- Reset values: ACL_MISO=0, regWrStrobe=0, regWrAddr=0, regWrData=0, xferDone=0; writable registers 0x1F–0x2E cleared; FSM in IDLE.
- SCLK, MOSI, CSN each pass through a 2-flop synchronizer. SCLK edges are detected from the synchronized value. MOSI is sampled on the SCLK rise. ACL_MISO updates on the SCLK fall.
- FSM states: IDLE, CMD, ADDR, WRITE, READ, IGNORE.
- IDLE→CMD on synchronized CSN fall. The same cycle snapshots xData/yData/zData into 0x08–0x0A, so multi-byte reads are coherent.
- CMD: shift 8 bits MSB first, then go to 0x0A→ADDR(write), 0x0B→ADDR(read), or any other value→IGNORE.
- ADDR: shift 8 bits. The low 6 bits form the address; the upper 2 bits are ignored. Then go to WRITE or READ.
- READ: on the SCLK fall that completes the address byte (and each later byte), load the shift register with reg[addr] and drive its MSB; increment the address.
- WRITE: on the 8th rise of each data byte, commit it. regWrStrobe/Addr/Data are valid the next cycle. Then increment the address.
- Address increments modulo 64 (0x3F→0x00).
- Writable range is 0x1F–0x2E. Writes elsewhere are dropped with no strobe. Reads of unmapped addresses return 0x00.
- Writing 0x52 to 0x1F (SOFT_RESET) clears 0x20–0x2E when CSN rises; 0x1F itself reads back 0x00.
- IGNORE: ACL_MISO held 0; all bits discarded until CSN rises.
- Any state→IDLE on synchronized CSN rise. A partial byte is discarded and xferDone pulses. If CSN never fell, there is no pulse.
- ACL_MISO is forced to 0 whenever CSN is high. It is not tri-stated.
- Bus resolution: SCLK ≤ 8 MHz. Each SCLK level must last ≥ 6 clk108MHz cycles.

## Timing
- Input-to-detection latency: 3 clk108MHz cycles (2 synchronizer stages plus the edge register).
- ACL_MISO is valid ≤ 4 cycles (37 ns) after the SCLK fall, well inside the 62.5 ns half-period.
- Write strobe: 1 cycle after the detected 8th rise of the byte.
- xferDone: 1 cycle after the detected CSN rise.
- resetPressed mid-transaction: immediate return to IDLE; outputs take reset values. The transaction resumes only after a fresh CSN fall.

## Structure
- Shared package acl_pkg holds:
  - command constants CMD_WRITE=8'h0A, CMD_READ=8'h0B
  - register addresses ADDR_XDATA, ADDR_YDATA, ADDR_ZDATA, ADDR_SOFT_RESET, WR_LO=6'h1F, WR_HI=6'h2E
  - SOFT_RESET_KEY=8'h52
  - the FSM state enum
- Sub-module spi_sync_edge (2-flop synchronizer plus rise/fall detect), instantiated for SCLK and CSN. MOSI uses its synchronizer only.

## Test plan
- Read 0x00 burst of 3 bytes at SCLK=5 MHz → MISO bytes 0xAD, 0x1D, 0xF2; xferDone pulses once.
- xData=0x12, yData=0xFE, zData=0x40, read from 0x08 burst of 3; change inputs mid-burst → returns 0x12, 0xFE, 0x40.
- Write 0x2C=0x13, 0x2D=0x02 in one burst → two strobes (0x2C,0x13), (0x2D,0x02); readback of 0x2C matches.
- Write to 0x08 and command 0x0D → no strobe, MISO stays 0; the next valid read succeeds.
- Burst read starting at 0x3F for 2 bytes → 0x00 (unmapped), then 0xAD (wrap); CSN raised after 4 bits of a write data byte → no strobe.
- Write 0x52 to 0x1F after loading 0x2D → 0x2D reads 0x00. Assert resetPressed mid-read → MISO=0 immediately.
